// File: rtl/shift_rows_stream.sv
// Column-streaming ShiftRows / InvShiftRows with two ping-pong block banks.
// One 32-bit column in and one out per cycle; shift direction travels with each block.
module shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_inv,
  output logic        out_last
);

  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  logic [31:0]   r_bank [2][NB];
  logic [1:0]    r_full;
  logic [1:0]    r_mode;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  logic          w_in_acc;
  logic          w_out_xfer;
  logic [31:0]   w_out_col;

  // Source column for row r of output column c; sums stay below 2*NB so one
  // conditional subtract replaces a modulo.
  function automatic logic [CW-1:0] src_col(input logic [CW-1:0] c, input int r,
                                            input logic inv);
    int s;
    int sum;
    s   = (NB == 8 && r >= 2) ? r + 1 : r;
    sum = inv ? int'(c) + NB - s : int'(c) + s;
    if (sum >= NB) sum = sum - NB;
    return sum[CW-1:0];
  endfunction

  assign in_ready   = !rst && !r_full[r_wr_ptr];
  assign out_valid  = r_full[r_rd_ptr];
  assign out_inv    = r_mode[r_rd_ptr];
  assign out_last   = r_full[r_rd_ptr] && (r_rd_cnt == LAST);
  assign out_col    = w_out_col;
  assign w_in_acc   = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_out_col = '0;
    for (int r = 0; r < 4; r++) begin
      w_out_col[8*r +: 8] = r_bank[r_rd_ptr][src_col(r_rd_cnt, r, r_mode[r_rd_ptr])][8*r +: 8];
    end
  end

  // Bank contents need no reset: they are only observed behind a full flag.
  always_ff @(posedge clk) begin
    if (w_in_acc) r_bank[r_wr_ptr][r_wr_cnt] <= in_col;
  end

  // Fill and drain always target different banks, so both may act in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= '0;
      r_mode   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_in_acc) begin
        if (r_wr_cnt == '0) r_mode[r_wr_ptr] <= in_inv;
        if (r_wr_cnt == LAST) begin
          r_full[r_wr_ptr] <= 1'b1;
          r_wr_cnt         <= '0;
          r_wr_ptr         <= ~r_wr_ptr;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_out_xfer) begin
        if (r_rd_cnt == LAST) begin
          r_full[r_rd_ptr] <= 1'b0;
          r_rd_cnt         <= '0;
          r_rd_ptr         <= ~r_rd_ptr;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream at NB = 4, 6 and 8 sharing one clock and reset.
// Expected columns come from hand-computed constants or an independent row-shift model.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [3];
  logic        in_ready [3];
  logic [31:0] in_col   [3];
  logic        in_inv   [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [31:0] out_col  [3];
  logic        out_inv  [3];
  logic        out_last [3];

  shift_rows_stream #(.NB(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_col(in_col[0]),
    .in_inv(in_inv[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_col(out_col[0]),
    .out_inv(out_inv[0]), .out_last(out_last[0]));
  shift_rows_stream #(.NB(6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_col(in_col[1]),
    .in_inv(in_inv[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_col(out_col[1]),
    .out_inv(out_inv[1]), .out_last(out_last[1]));
  shift_rows_stream #(.NB(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_col(in_col[2]),
    .in_inv(in_inv[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_col(out_col[2]),
    .out_inv(out_inv[2]), .out_last(out_last[2]));

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] src_q[3][$];   // {inv, col} waiting to be offered
  logic [33:0] exp_q[3][$];   // {inv, last, col} expected at the output
  logic [31:0] acc_blk[3][8];
  logic        acc_mode[3];
  int          acc_cnt[3];
  bit          use_model[3];
  int          vprob[3];
  int          rprob[3];
  int          n_acc[3];
  int          n_xfer[3];
  int          nb_of[3] = '{4, 6, 8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_col(input int k, input int c, input logic inv);
    int          t8[4] = '{0, 1, 3, 4};
    int          nb;
    int          s;
    int          src;
    logic [31:0] res;
    nb  = nb_of[k];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      s   = (nb == 8) ? t8[r] : r;
      src = inv ? (c - s + nb) % nb : (c + s) % nb;
      res[8*r +: 8] = acc_blk[k][src][8*r +: 8];
    end
    return res;
  endfunction

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = (src_q[k].size() > 0) && ($urandom_range(99) < vprob[k]);
      if (in_valid[k]) {in_inv[k], in_col[k]} = src_q[k][0];
      else begin
        in_inv[k] = 1'b0;
        in_col[k] = $urandom;
      end
      out_ready[k] = ($urandom_range(99) < rprob[k]);
    end
  endtask

  task automatic step();
    bit          acc[3];
    logic [33:0] e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      acc[k] = in_valid[k] && in_ready[k];
      if (out_valid[k] && out_ready[k]) begin
        n_xfer[k]++;
        if (exp_q[k].size() == 0) check($sformatf("k%0d_unexpected_out", k), 1, 0);
        else begin
          e = exp_q[k].pop_front();
          check($sformatf("k%0d_col", k), out_col[k], e[31:0]);
          check($sformatf("k%0d_inv", k), out_inv[k], e[33]);
          check($sformatf("k%0d_last", k), out_last[k], e[32]);
        end
      end
      if (acc[k]) begin
        n_acc[k]++;
        if (acc_cnt[k] == 0) acc_mode[k] = in_inv[k];
        acc_blk[k][acc_cnt[k]] = in_col[k];
        if (acc_cnt[k] == nb_of[k] - 1) begin
          if (use_model[k])
            for (int c = 0; c < nb_of[k]; c++)
              exp_q[k].push_back({acc_mode[k], c == nb_of[k] - 1, model_col(k, c, acc_mode[k])});
          acc_cnt[k] = 0;
        end else acc_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (acc[k]) void'(src_q[k].pop_front());
    drive();
  endtask

  task automatic push_exp(input int k, input logic [31:0] col, input logic inv, input logic last);
    exp_q[k].push_back({inv, last, col});
  endtask

  task automatic push_blk_std(input int k, input logic inv);
    logic [31:0] col;
    for (int c = 0; c < nb_of[k]; c++) begin
      for (int r = 0; r < 4; r++) col[8*r +: 8] = 8'(4*c + r);
      src_q[k].push_back({(c == 0) ? inv : 1'b0, col});
    end
  endtask

  task automatic push_blk_rand(input int k, input logic inv);
    for (int c = 0; c < nb_of[k]; c++)
      src_q[k].push_back({(c == 0) ? inv : 1'($urandom_range(1)), 32'($urandom)});
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n = 0;
    while ((exp_q[k].size() != 0 || src_q[k].size() != 0) && n < budget) begin
      step();
      n++;
    end
    check($sformatf("k%0d_drain_left", k), 64'(exp_q[k].size() + src_q[k].size()), 0);
  endtask

  int a0;
  int x0;
  int n;
  logic [31:0] fwd4 [4] = '{32'h0F0A0500, 32'h030E0904, 32'h07020D08, 32'h0B06010C};
  logic [31:0] inv4 [4] = '{32'h070A0D00, 32'h0B0E0104, 32'h0F020508, 32'h0306090C};
  logic [31:0] fwd8 [8] = '{32'h130E0500, 32'h17120904, 32'h1B160D08, 32'h1F1A110C,
                            32'h031E1510, 32'h07021914, 32'h0B061D18, 32'h0F0A011C};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vprob[k] = 100; rprob[k] = 0; use_model[k] = 1'b1;
      acc_cnt[k] = 0; n_acc[k] = 0; n_xfer[k] = 0; acc_mode[k] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d_rst_out_valid", k), out_valid[k], 0);
      check($sformatf("k%0d_rst_in_ready", k), in_ready[k], 0);
      check($sformatf("k%0d_rst_out_last", k), out_last[k], 0);
      check($sformatf("k%0d_rst_out_inv", k), out_inv[k], 0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("k%0d_post_rst_in_ready", k), in_ready[k], 1);

    // NB=4 forward with latency check
    use_model[0] = 1'b0;
    for (int c = 0; c < 4; c++) push_exp(0, fwd4[c], 1'b0, c == 3);
    push_blk_std(0, 1'b0);
    rprob[0] = 100;
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) check("fwd4_valid_early", out_valid[0], 0);
      if (i == 3) check("fwd4_latency", out_valid[0], 1);
    end
    wait_drain(0, 40);

    // NB=4 inverse, then the inverse result fed forward must restore the input
    for (int c = 0; c < 4; c++) push_exp(0, inv4[c], 1'b1, c == 3);
    push_blk_std(0, 1'b1);
    drive();
    wait_drain(0, 40);
    for (int c = 0; c < 4; c++) begin
      src_q[0].push_back({1'b0, inv4[c]});
      push_exp(0, {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)}, 1'b0, c == 3);
    end
    drive();
    wait_drain(0, 40);
    use_model[0] = 1'b1;

    // NB=8 forward
    use_model[2] = 1'b0;
    for (int c = 0; c < 8; c++) push_exp(2, fwd8[c], 1'b0, c == 7);
    push_blk_std(2, 1'b0);
    rprob[2] = 100;
    drive();
    wait_drain(2, 60);
    use_model[2] = 1'b1;

    // Backpressure with fwd/inv/fwd mixing on NB=4
    rprob[0] = 0;
    push_blk_rand(0, 1'b0);
    push_blk_rand(0, 1'b1);
    push_blk_rand(0, 1'b0);
    drive();
    a0 = n_acc[0];
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 6) check("bp_ready_before_full", in_ready[0], 1);
      if (i == 7) check("bp_ready_after_8", in_ready[0], 0);
    end
    step();
    step();
    check("bp_accepts_held", 64'(n_acc[0] - a0), 8);
    rprob[0] = 100;
    drive();
    x0 = n_xfer[0];
    for (int i = 0; i < 12; i++) begin
      check("bp_no_gap", out_valid[0], 1);
      step();
      if (i == 2) check("bp_ready_3rd_xfer", in_ready[0], 0);
      if (i == 3) check("bp_ready_4th_xfer", in_ready[0], 1);
    end
    check("bp_xfer_count", 64'(n_xfer[0] - x0), 12);
    wait_drain(0, 40);

    // Reset with block A half drained and two columns of block B written
    rprob[0] = 0;
    push_blk_rand(0, 1'b1);
    drive();
    for (int i = 0; i < 4; i++) step();
    rprob[0] = 100;
    src_q[0].push_back({1'b0, 32'($urandom)});
    src_q[0].push_back({1'b0, 32'($urandom)});
    drive();
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      acc_cnt[k] = 0;
    end
    rprob[0] = 0;
    drive();
    #1;
    check("rst_mid_in_ready_now", in_ready[0], 0);
    step();
    check("rst_mid_out_valid", out_valid[0], 0);
    check("rst_mid_in_ready", in_ready[0], 0);
    check("rst_mid_out_last", out_last[0], 0);
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready_after", in_ready[0], 1);
    rprob[0] = 100;
    push_blk_std(0, 1'b1);
    drive();
    wait_drain(0, 40);

    // Random soak on all three widths at once
    for (int k = 0; k < 3; k++) begin
      vprob[k] = 70;
      rprob[k] = 70;
      for (int b = 0; b < 1000; b++) push_blk_rand(k, 1'($urandom_range(1)));
    end
    drive();
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() +
            exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 50000) begin
      step();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("soak_k%0d_exp_left", k), 64'(exp_q[k].size()), 0);
      check($sformatf("soak_k%0d_src_left", k), 64'(src_q[k].size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Column-streaming, parametrised AES/Rijndael ShiftRows / InvShiftRows unit for the cipher datapath. It accepts the state one 32-bit column per cycle over a valid/ready handshake and buffers a full block in one of two ping-pong banks. It then emits the row-shifted state one column per cycle, with the shift direction selected per block. It replaces the combinational 4×4 row shifter wherever the datapath is column-serial or the block size exceeds 128 bits.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_col is valid this cycle.
- in_ready  out  1  block can accept a column this cycle.
- in_col  in  32  input column; byte r, bits [8r+7:8r], is row r.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled only with the first column of a block.
- out_valid  out  1  out_col is valid.
- out_ready  in  1  sink accepts out_col this cycle.
- out_col  out  32  output column; byte r is row r.
- out_inv  out  1  mode of the block currently being emitted.
- out_last  out  1  out_col is column NB-1 of its block.

## Operation
- Row offsets s_r for r = 0..3:
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward mode: output column c, row r = input column (c + s_r) mod NB, row r.
- Inverse mode: output column c, row r = input column (c − s_r + NB) mod NB, row r. All index arithmetic is mod NB; no carries leave the index width.
- Storage is two banks of NB×4 bytes. Each bank has a full flag and a mode bit.
- wr_ptr and rd_ptr are 1 bit each. wr_cnt and rd_cnt are ceil(log2 NB) bits and wrap from NB−1 to 0.
- Input accept = in_valid & in_ready.
  - On accept, in_col is written to bank[wr_ptr] column wr_cnt.
  - When wr_cnt = 0, in_inv is captured into that bank's mode bit. in_inv is ignored on all other columns.
  - When wr_cnt = NB−1: set full[wr_ptr], wrap wr_cnt, toggle wr_ptr.
- in_ready = !rst & !full[wr_ptr].
- out_valid = full[rd_ptr].
- out_col is a combinational mux from bank[rd_ptr], indexed by rd_cnt and that bank's mode bit.
- out_inv = mode[rd_ptr]. out_last = out_valid & (rd_cnt = NB−1).
- Output transfer = out_valid & out_ready.
  - Each transfer increments rd_cnt.
  - At rd_cnt = NB−1: clear full[rd_ptr], wrap rd_cnt, toggle rd_ptr.
- Blocks leave in arrival order. Each block keeps its own mode even when consecutive blocks differ.
- Simultaneous events:
  - Fill of one bank and drain of the other in the same cycle: both take effect.
  - A bank freed by the final read is writable from the next cycle. in_ready is not combinationally dependent on out_ready.
- Reset, including mid-block:
  - full flags, pointers and counters go to 0, and partially written or undrained blocks are discarded.
  - Reset values: out_valid=0, out_last=0, out_inv=0, in_ready=0 while rst is high.
  - out_col is don't-care while out_valid=0.

## Timing
- Latency: the final column of a block is accepted at edge t. At edge t+1, out_valid=1 with column 0.
- Throughput: sustained 1 column/cycle in and out when out_ready is held high. There are no bubbles between blocks.
- Buffering:
  - At most 2 blocks are held.
  - With out_ready low, in_ready falls after exactly 2·NB accepted columns.
  - in_ready rises the cycle after the last column of the oldest block transfers.
- out_col, out_inv and out_last hold stable while out_valid=1 and out_ready=0.
- Inputs are registered; output datapath = one mux level from bank registers; no combinational in→out path.

## Test plan
- NB=4 forward: columns 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, in_inv=0, out_ready=1.
  - Required output: 0x0F0A0500, 0x030E0904, 0x07020D08, 0x0B06010C.
  - out_valid must appear 1 cycle after the 4th accept; out_last only on the 4th output.
- NB=4 inverse: same input, in_inv=1.
  - Required output: 0x070A0D00, 0x0B0E0104, 0x0F020508, 0x0306090C, with out_inv=1.
  - Feeding this output back with in_inv=0 must return the original columns.
- NB=8 forward: column c = bytes 4c+r (0x03020100 … 0x1F1E1D1C).
  - Required output column 0: 0x130E0500.
  - Required output column 7: 0x0F0A011C.
- Backpressure and mode mixing: out_ready=0, stream 3 back-to-back NB=4 blocks with modes fwd, inv, fwd.
  - in_ready must drop after the 8th accept.
  - Then release out_ready: 12 columns emerge with correct per-block out_inv and no gaps. in_ready must rise exactly 1 cycle after the 4th output transfer.
- Reset mid-operation: assert rst for 1 cycle after 2 columns of block B, while block A is half-drained.
  - out_valid=0 and in_ready=0 during reset. in_ready=1 the cycle after.
  - A new full block must produce correct output, with no residue from A or B.
- Random soak: random in_valid/out_ready stalls and random modes, 1000 blocks per legal NB, checked against a reference model.
